// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared sizing and one-hot helper for the register scoreboard
package reg_scoreboard_pkg;

    localparam int ADDR_W_DEF = 4;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

    function automatic logic [DEPTH_DEF-1:0] onehot(input logic [ADDR_W_DEF-1:0] addr);
        logic [DEPTH_DEF-1:0] v;
        v = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - generalised ADDR_W to 2**ADDR_W one-hot decoder
module onehot_dec #(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [(1<<ADDR_W)-1:0] oh
);

    always_comb begin
        oh = '0;
        oh[addr] = 1'b1;
    end

endmodule

// File: rtl/reg_scoreboard_dec.sv
// rtl/reg_scoreboard_dec.sv - register scoreboard: RAW/WAW issue stall and registered write-enable decode
module reg_scoreboard_dec
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iss_valid,
    input  logic [ADDR_W-1:0]             iss_rd,
    input  logic [ADDR_W-1:0]             iss_rs1,
    input  logic [ADDR_W-1:0]             iss_rs2,
    output logic                          iss_ready,
    output logic [depth_of(ADDR_W)-1:0]   dec_onehot,
    input  logic                          ret_valid,
    input  logic [ADDR_W-1:0]             ret_rd,
    output logic [depth_of(ADDR_W)-1:0]   we_onehot,
    output logic [depth_of(ADDR_W)-1:0]   pending,
    output logic [ADDR_W:0]               busy_cnt,
    output logic                          err
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [DEPTH-1:0] ret_mask;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] eff_pend;
    logic             ret_hit;
    logic             iss_fire;

    onehot_dec #(.ADDR_W(ADDR_W)) u_dec_iss (.addr(iss_rd), .oh(dec_onehot));
    onehot_dec #(.ADDR_W(ADDR_W)) u_dec_ret (.addr(ret_rd), .oh(ret_mask));
    onehot_dec #(.ADDR_W(ADDR_W)) u_dec_set (.addr(iss_rd), .oh(set_mask));

    // A retiring register is treated as free in the same cycle so the dependent issue need not wait.
    always_comb begin
        ret_hit  = ret_valid && pending[ret_rd];
        eff_pend = ret_hit ? (pending & ~ret_mask) : pending;
        iss_ready = !rst && !eff_pend[iss_rd] && !eff_pend[iss_rs1] && !eff_pend[iss_rs2];
        iss_fire = iss_valid && iss_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            we_onehot <= '0;
            busy_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            pending   <= eff_pend | (iss_fire ? set_mask : '0);
            we_onehot <= ret_hit ? ret_mask : '0;
            err       <= err | (ret_valid && !ret_hit);
            // Simultaneous set and clear leave the population count unchanged.
            if (iss_fire && !ret_hit)
                busy_cnt <= busy_cnt + CNT_ONE;
            else if (ret_hit && !iss_fire)
                busy_cnt <= busy_cnt - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard_dec.sv
// tb/tb_reg_scoreboard_dec.sv - directed self-checking bench for reg_scoreboard_dec (ADDR_W 4 and 5)
module tb_reg_scoreboard_dec;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_iss_valid, a_ret_valid, a_iss_ready, a_err;
    logic [3:0]  a_iss_rd, a_iss_rs1, a_iss_rs2, a_ret_rd;
    logic [15:0] a_dec_onehot, a_we_onehot, a_pending;
    logic [4:0]  a_busy_cnt;

    logic        b_iss_valid, b_ret_valid, b_iss_ready, b_err;
    logic [4:0]  b_iss_rd, b_iss_rs1, b_iss_rs2, b_ret_rd;
    logic [31:0] b_dec_onehot, b_we_onehot, b_pending;
    logic [5:0]  b_busy_cnt;

    int checks = 0;
    int errors = 0;

    reg_scoreboard_dec #(.ADDR_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .iss_valid(a_iss_valid), .iss_rd(a_iss_rd), .iss_rs1(a_iss_rs1), .iss_rs2(a_iss_rs2),
        .iss_ready(a_iss_ready), .dec_onehot(a_dec_onehot),
        .ret_valid(a_ret_valid), .ret_rd(a_ret_rd),
        .we_onehot(a_we_onehot), .pending(a_pending), .busy_cnt(a_busy_cnt), .err(a_err)
    );

    reg_scoreboard_dec #(.ADDR_W(5)) dut_b (
        .clk(clk), .rst(rst),
        .iss_valid(b_iss_valid), .iss_rd(b_iss_rd), .iss_rs1(b_iss_rs1), .iss_rs2(b_iss_rs2),
        .iss_ready(b_iss_ready), .dec_onehot(b_dec_onehot),
        .ret_valid(b_ret_valid), .ret_rd(b_ret_rd),
        .we_onehot(b_we_onehot), .pending(b_pending), .busy_cnt(b_busy_cnt), .err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic inv();
        chk("a_popcount", 32'(a_busy_cnt), 32'($countones(a_pending)));
        chk("b_popcount", 32'(b_busy_cnt), 32'($countones(b_pending)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_iss(input logic v, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        a_iss_valid = v; a_iss_rd = rd; a_iss_rs1 = rs1; a_iss_rs2 = rs2;
    endtask

    task automatic a_ret(input logic v, input logic [3:0] rd);
        a_ret_valid = v; a_ret_rd = rd;
    endtask

    initial begin
        rst = 1'b1;
        a_iss(1'b0, 4'd0, 4'd0, 4'd0);
        a_ret(1'b0, 4'd0);
        b_iss_valid = 1'b0; b_iss_rd = '0; b_iss_rs1 = '0; b_iss_rs2 = '0;
        b_ret_valid = 1'b0; b_ret_rd = '0;
        #1;
        chk("ready_in_reset", 32'(a_iss_ready), 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_pending", 32'(a_pending), 32'h0);
        chk("rst_busy", 32'(a_busy_cnt), 32'd0);
        chk("rst_ready", 32'(a_iss_ready), 32'd1);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_we", 32'(a_we_onehot), 32'h0);

        // RAW stall on r5, released by the retire bypass
        a_iss(1'b1, 4'd5, 4'd0, 4'd0);
        #1;
        chk("dec_r5", 32'(a_dec_onehot), 32'h0020);
        tick();
        chk("pend_r5", 32'(a_pending), 32'h0020);
        chk("busy_r5", 32'(a_busy_cnt), 32'd1);
        a_iss(1'b1, 4'd6, 4'd5, 4'd0);
        #1;
        chk("raw_stall", 32'(a_iss_ready), 32'd0);
        tick();
        chk("stall_pend", 32'(a_pending), 32'h0020);
        a_ret(1'b1, 4'd5);
        #1;
        chk("bypass_ready", 32'(a_iss_ready), 32'd1);
        tick();
        a_iss(1'b0, 4'd0, 4'd0, 4'd0);
        a_ret(1'b0, 4'd0);
        chk("we_r5", 32'(a_we_onehot), 32'h0020);
        chk("pend_after_bypass", 32'(a_pending), 32'h0040);
        chk("busy_after_bypass", 32'(a_busy_cnt), 32'd1);
        inv();
        tick();
        chk("we_pulse_end", 32'(a_we_onehot), 32'h0);

        // same-cycle retire and reissue of r3
        a_iss(1'b1, 4'd3, 4'd0, 4'd0);
        tick();
        chk("pend_r3", 32'(a_pending), 32'h0048);
        a_ret(1'b1, 4'd3);
        #1;
        chk("same_ready", 32'(a_iss_ready), 32'd1);
        tick();
        a_iss(1'b0, 4'd0, 4'd0, 4'd0);
        chk("same_we", 32'(a_we_onehot), 32'h0008);
        chk("same_pend", 32'(a_pending), 32'h0048);
        chk("same_busy", 32'(a_busy_cnt), 32'd2);

        // back-to-back retires of r3 then r6
        tick();
        chk("b2b_we0", 32'(a_we_onehot), 32'h0008);
        a_ret(1'b1, 4'd6);
        tick();
        a_ret(1'b0, 4'd0);
        chk("b2b_we1", 32'(a_we_onehot), 32'h0040);
        chk("b2b_pend", 32'(a_pending), 32'h0);
        chk("b2b_busy", 32'(a_busy_cnt), 32'd0);
        chk("b2b_err", 32'(a_err), 32'd0);
        inv();

        // fill all 16
        for (int i = 0; i < 16; i++) begin
            a_iss(1'b1, 4'(i), 4'(i), 4'(i));
            tick();
        end
        chk("full_busy", 32'(a_busy_cnt), 32'd16);
        chk("full_pend", 32'(a_pending), 32'hFFFF);
        a_iss(1'b1, 4'd7, 4'd0, 4'd1);
        #1;
        chk("full_stall", 32'(a_iss_ready), 32'd0);
        inv();
        a_iss(1'b0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            a_ret(1'b1, 4'(15 - i));
            tick();
        end
        a_ret(1'b0, 4'd0);
        chk("drain_we", 32'(a_we_onehot), 32'h0001);
        chk("drain_busy", 32'(a_busy_cnt), 32'd0);
        chk("drain_pend", 32'(a_pending), 32'h0);

        // retire of a non-pending register
        a_iss(1'b1, 4'd2, 4'd2, 4'd2);
        tick();
        a_iss(1'b0, 4'd0, 4'd0, 4'd0);
        a_ret(1'b1, 4'd9);
        tick();
        a_ret(1'b0, 4'd0);
        chk("bad_err", 32'(a_err), 32'd1);
        chk("bad_we", 32'(a_we_onehot), 32'h0);
        chk("bad_pend", 32'(a_pending), 32'h0004);
        chk("bad_busy", 32'(a_busy_cnt), 32'd1);
        tick();
        chk("err_sticky", 32'(a_err), 32'd1);

        // ADDR_W = 5
        b_iss_valid = 1'b1; b_iss_rd = 5'd31;
        #1;
        chk("b_dec31", b_dec_onehot, 32'h8000_0000);
        tick();
        chk("b_pend31", b_pending, 32'h8000_0000);
        for (int i = 1; i < 4; i++) begin
            b_iss_rd = 5'(i);
            tick();
        end
        b_iss_valid = 1'b0;
        b_ret_valid = 1'b1; b_ret_rd = 5'd20;
        tick();
        b_ret_valid = 1'b0;
        chk("b_pend4", b_pending, 32'h8000_000E);
        chk("b_busy4", 32'(b_busy_cnt), 32'd4);
        chk("b_err", 32'(b_err), 32'd1);
        inv();

        // reset with traffic present: both discarded
        rst = 1'b1;
        b_ret_valid = 1'b1; b_ret_rd = 5'd31;
        b_iss_valid = 1'b1; b_iss_rd = 5'd7;
        a_ret(1'b1, 4'd2);
        #1;
        chk("b_ready_rst", 32'(b_iss_ready), 32'd0);
        tick();
        rst = 1'b0;
        b_ret_valid = 1'b0; b_iss_valid = 1'b0;
        a_ret(1'b0, 4'd0);
        #1;
        chk("b_rst_pend", b_pending, 32'h0);
        chk("b_rst_busy", 32'(b_busy_cnt), 32'd0);
        chk("b_rst_we", b_we_onehot, 32'h0);
        chk("b_rst_err", 32'(b_err), 32'd0);
        chk("a_rst_err", 32'(a_err), 32'd0);
        chk("a_rst_pend", 32'(a_pending), 32'h0);
        chk("a_rst_we", 32'(a_we_onehot), 32'h0);
        inv();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard_dec.md
# reg_scoreboard_dec

Parametrised register scoreboard built around a generalised N-to-2^N one-hot decoder. It tracks which architectural registers have an outstanding write. It stalls issue on read-after-write and write-after-write hazards, and emits a registered one-hot write-enable vector for the register file when a write retires. It sits between instruction decode and the register file, replacing the fixed 4-to-16 write-select decode.

## Interface
- ADDR_W, default 4: register address width.
- DEPTH, default 2**ADDR_W: number of tracked registers. Derived, not overridable.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- iss_valid  in  1  issue request.
- iss_rd  in  ADDR_W  destination register of the issuing instruction.
- iss_rs1  in  ADDR_W  first source register.
- iss_rs2  in  ADDR_W  second source register.
- iss_ready  out  1  issue accepted this cycle when iss_valid && iss_ready. Combinational.
- dec_onehot  out  DEPTH  combinational one-hot decode of iss_rd. Always driven, independent of iss_valid.
- ret_valid  in  1  retire (write-back) request. Always accepted.
- ret_rd  in  ADDR_W  register being written back.
- we_onehot  out  DEPTH  registered one-hot register-file write enable.
- pending  out  DEPTH  registered bitmap of outstanding writes.
- busy_cnt  out  ADDR_W+1  registered count of set pending bits, range 0..DEPTH.
- err  out  1  sticky error flag: a retire targeted a non-pending register.

## Operation
- ret_hit = ret_valid && pending[ret_rd].
- eff_pend = pending with bit ret_rd cleared when ret_hit. This is the same-cycle retire bypass.
- iss_ready = !rst && !eff_pend[iss_rd] && !eff_pend[iss_rs1] && !eff_pend[iss_rs2].
- Issue fire (iss_valid && iss_ready): pending[iss_rd] is set next cycle.
- ret_hit: pending[ret_rd] is cleared next cycle, and we_onehot = onehot(ret_rd) for exactly one cycle.
- Retire and issue to the same register in the same cycle: the set wins. pending stays 1, and the we_onehot pulse is still produced.
- ret_valid with pending[ret_rd] = 0:
  - no pending change;
  - we_onehot stays all-zero;
  - err is set and held until rst.
- busy_cnt is updated incrementally:
  - +1 on issue fire only;
  - -1 on ret_hit only;
  - unchanged when both or neither occur.
- busy_cnt never exceeds DEPTH, because issue to a pending rd is blocked.
- Invariant: busy_cnt == popcount(pending) in every cycle. The verifier checks this with an assertion.
- Source and destination may be the same register (rs1 == rs2 == rd). The hazard check is the same as for distinct registers.
- There is no state machine beyond the pending bitmap. Every bit is an independent set/clear flop.

## Timing
- Reset values: pending = 0, we_onehot = 0, busy_cnt = 0, err = 0.
- iss_ready = 0 while rst is high.
- dec_onehot follows iss_rd combinationally.
- Issue-to-pending latency: 1 cycle.
- Retire-to-we_onehot latency: 1 cycle. The pulse is 1 cycle wide.
- Back-to-back retires produce back-to-back we_onehot pulses.
- iss_ready depends combinationally on ret_valid/ret_rd through the bypass. There is no combinational path from iss_valid to iss_ready.
- rst asserted mid-operation:
  - next cycle all state is zero;
  - any retire or issue presented in the reset cycle is discarded;
  - err is cleared.

## Structure
- Shared package reg_scoreboard_pkg holds:
  - the ADDR_W default;
  - the DEPTH derivation;
  - a function onehot(addr) returning a DEPTH-bit vector.
- Sub-module onehot_dec (parameter ADDR_W; in addr, out DEPTH-bit one-hot) is the generalised decoder. It is instantiated three times: for dec_onehot, for the retire mask, and for the issue set mask.
- The hazard mux (eff_pend indexed by rd/rs1/rs2) stays in the top level.

## Test plan
- Reset release, ADDR_W = 4, no traffic: pending = 0, busy_cnt = 0, iss_ready = 1, err = 0, we_onehot = 0.
- Issue rd = 5, then one cycle later issue rs1 = 5: pending = 0x0020 and busy_cnt = 1; second issue sees iss_ready = 0 (RAW stall). Retire 5: we_onehot = 0x0020 for 1 cycle, then the stalled issue fires.
- Same cycle: retire rd = 3 (pending) and issue rd = 3. Required: iss_ready = 1, we_onehot = 0x0008 next cycle, pending[3] stays 1, busy_cnt unchanged.
- Issue all 16 registers, one per cycle: busy_cnt reaches 16, pending = 0xFFFF, and every further issue is stalled. Retire all 16: busy_cnt = 0.
- Retire rd = 9 while not pending: err = 1 and stays set, we_onehot stays 0, pending unchanged. A later rst clears err.
- ADDR_W = 5: issue rd = 31 gives pending bit 31 set and dec_onehot = 0x8000_0000. Assert rst with 4 writes pending: next cycle everything is zero.
